// File: rtl/ltc2624_spi_writer.sv
// LTC2624 SPI frame writer: one 32-bit {8'h00,CMD,addr,data,4'h0} frame per accepted start, readback captured into echo.
// Frame takes 66*CLKDIV cycles from acceptance to done; start is ignored (not queued) while busy.
module ltc2624_spi_writer #(
    parameter int         CLKDIV     = 2,
    parameter logic [3:0] CMD        = 4'b0011,
    parameter int         CLR_CYCLES = 4
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        start,
    input  logic [3:0]  addr,
    input  logic [11:0] data,
    output logic        busy,
    output logic        done,
    output logic [31:0] echo,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR,
    input  logic        DAC_OUT
);

    localparam int PW = $clog2(CLKDIV) + 1;
    localparam int CW = $clog2(CLR_CYCLES) + 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CLKDIV - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t         state, state_d;
    logic [PW-1:0]  ph, ph_d;
    logic           hi, hi_d;
    logic [5:0]     bitn, bitn_d;
    logic [CW-1:0]  clr_cnt, clr_cnt_d;
    logic [31:0]    tx, tx_d;
    logic [31:0]    cap, cap_d;
    logic [31:0]    echo_d;
    logic           sck_d, mosi_d, cs_d, clr_d, busy_d, done_d;
    logic [31:0]    frame;
    logic           ph_last;

    assign frame   = {8'h00, CMD, addr, data, 4'h0};
    assign ph_last = (ph == PH_LAST);

    // All pin-facing outputs are registered from next-state values so SCK/CS never glitch.
    always_comb begin
        state_d   = state;
        ph_d      = ph;
        hi_d      = hi;
        bitn_d    = bitn;
        clr_cnt_d = clr_cnt;
        tx_d      = tx;
        cap_d     = cap;
        echo_d    = echo;
        sck_d     = 1'b0;
        mosi_d    = 1'b0;
        cs_d      = 1'b1;
        clr_d     = 1'b1;
        busy_d    = 1'b1;
        done_d    = 1'b0;

        case (state)
            S_CLEAR: begin
                clr_d = 1'b0;
                if (clr_cnt == CLR_LAST) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_SETUP;
                    tx_d    = frame;
                    mosi_d  = frame[31];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    ph_d    = '0;
                end
            end
            S_SETUP: begin
                cs_d   = 1'b0;
                mosi_d = tx[31];
                ph_d   = ph_last ? '0 : ph + 1'b1;
                if (ph_last) begin
                    state_d = S_SHIFT;
                    hi_d    = 1'b1;
                    sck_d   = 1'b1;
                    bitn_d  = '0;
                    cap_d   = {cap[30:0], DAC_OUT};
                end
            end
            S_SHIFT: begin
                cs_d   = 1'b0;
                mosi_d = tx[31];
                sck_d  = hi;
                ph_d   = ph_last ? '0 : ph + 1'b1;
                if (ph_last) begin
                    if (hi) begin
                        hi_d   = 1'b0;
                        sck_d  = 1'b0;
                        tx_d   = {tx[30:0], 1'b0};
                        mosi_d = tx[30];
                    end else if (bitn == 6'd31) begin
                        // Last low phase done: close the frame.
                        state_d = S_GAP;
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                    end else begin
                        hi_d   = 1'b1;
                        sck_d  = 1'b1;
                        bitn_d = bitn + 1'b1;
                        cap_d  = {cap[30:0], DAC_OUT};
                    end
                end
            end
            S_GAP: begin
                ph_d = ph_last ? '0 : ph + 1'b1;
                if (ph_last) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    echo_d  = cap;
                end
            end
            default: begin
                state_d = S_CLEAR;
                clr_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state    <= S_CLEAR;
            ph       <= '0;
            hi       <= 1'b0;
            bitn     <= '0;
            clr_cnt  <= '0;
            tx       <= '0;
            cap      <= '0;
            echo     <= '0;
            SPI_SCK  <= 1'b0;
            SPI_MOSI <= 1'b0;
            DAC_CS   <= 1'b1;
            DAC_CLR  <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            ph       <= ph_d;
            hi       <= hi_d;
            bitn     <= bitn_d;
            clr_cnt  <= clr_cnt_d;
            tx       <= tx_d;
            cap      <= cap_d;
            echo     <= echo_d;
            SPI_SCK  <= sck_d;
            SPI_MOSI <= mosi_d;
            DAC_CS   <= cs_d;
            DAC_CLR  <= clr_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule
